// File: rtl/cache_mem_ctrl.sv
// Responder end of the cache-to-memory protocol: arbitrates icache/dcache word accesses onto one RAM.
// Define MEMCTRL_STATS_EN to add the dword_cnt/iword_cnt completed-word counters.
module cache_mem_ctrl #(
    parameter int MAX_DSTREAK = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_rdy,
`ifdef MEMCTRL_STATS_EN
    output logic [31:0] dword_cnt,
    output logic [31:0] iword_cnt,
`endif
    output logic        ram_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DSVC = 2'd1,
        ISVC = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_LAST = 4'(MAX_DSTREAK - 1);
    localparam logic [7:0] TMO_LIMIT   = 8'(TIMEOUT);

    state_t     state;
    state_t     next_state;
    logic [3:0] streak;
    logic [3:0] next_streak;
    logic [7:0] tmo;
    logic [7:0] next_tmo;

    logic dreq;
    logic d_done;
    logic i_done;
    logic strobe;

    // A word only completes while its requester still asserts the request.
    assign dreq   = dREN | dWEN;
    assign d_done = (state == DSVC) && dreq && ram_rdy;
    assign i_done = (state == ISVC) && iREN && ram_rdy;
    assign strobe = ((state == DSVC) && dreq) || ((state == ISVC) && iREN);

    assign iload = ramload;
    assign dload = ramload;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            DSVC: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~d_done;
            end
            ISVC: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~i_done;
            end
            default: ;
        endcase
    end

    // Arbitration: dcache wins, but after MAX_DSTREAK back-to-back dcache words a waiting icache word goes next.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq)
                    next_state = DSVC;
                else if (iREN)
                    next_state = ISVC;
            end
            DSVC: begin
                if (!dreq)
                    next_state = iREN ? ISVC : IDLE;
                else if (d_done && iREN && (streak == STREAK_LAST))
                    next_state = ISVC;
            end
            ISVC: begin
                if (i_done || !iREN) begin
                    if (dreq)
                        next_state = DSVC;
                    else if (iREN)
                        next_state = ISVC;
                    else
                        next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        next_streak = '0;
        if ((state == DSVC) && (next_state == DSVC)) begin
            next_streak = streak;
            if (d_done && (streak != STREAK_LAST))
                next_streak = streak + 4'd1;
        end
    end

    // The timeout counter holds at its limit so a very long stall cannot wrap it back below.
    always_comb begin
        next_tmo = '0;
        if ((state != IDLE) && !ram_rdy && (next_state == state)) begin
            next_tmo = tmo;
            if (strobe && (tmo != TMO_LIMIT))
                next_tmo = tmo + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            streak    <= '0;
            tmo       <= '0;
            ram_err   <= 1'b0;
`ifdef MEMCTRL_STATS_EN
            dword_cnt <= '0;
            iword_cnt <= '0;
`endif
        end else begin
            state   <= next_state;
            streak  <= next_streak;
            tmo     <= next_tmo;
            ram_err <= ram_err | (next_tmo == TMO_LIMIT);
`ifdef MEMCTRL_STATS_EN
            if (d_done)
                dword_cnt <= dword_cnt + 32'd1;
            if (i_done)
                iword_cnt <= iword_cnt + 32'd1;
`endif
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: directed vector table, multi-cycle corner sequences and a randomized
// run checked against a grant-level behavioural model.
module tb_cache_mem_ctrl;

    localparam int MAX_D = 8;
    localparam int TMO_L = 255;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_rdy;
    logic        ram_err;
`ifdef MEMCTRL_STATS_EN
    logic [31:0] dword_cnt;
    logic [31:0] iword_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: who currently holds the RAM (0 none, 1 dcache, 2 icache) plus the rule counters.
    int          mGrant;
    int          mStreak;
    int          mTmo;
    logic        mErr;
    logic [31:0] mDcnt;
    logic [31:0] mIcnt;

    cache_mem_ctrl #(.MAX_DSTREAK(MAX_D), .TIMEOUT(TMO_L)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_rdy(ram_rdy),
`ifdef MEMCTRL_STATS_EN
        .dword_cnt(dword_cnt), .iword_cnt(iword_cnt),
`endif
        .ram_err(ram_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren;
        logic        dren;
        logic        dwen;
        logic        rdy;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] ds;
        logic [31:0] rl;
        logic        eIwait;
        logic        eDwait;
        logic        eRen;
        logic        eWen;
        logic [31:0] eAddr;
        logic [31:0] eStore;
    } vec_t;

    vec_t vecs[16];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic dr, input logic dw, input logic rdy,
                                 input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] ds, input logic [31:0] rl);
        iREN    = ir;
        dREN    = dr;
        dWEN    = dw;
        ram_rdy = rdy;
        iaddr   = ia;
        daddr   = da;
        dstore  = ds;
        ramload = rl;
    endtask

    task automatic modelReset();
        mGrant  = 0;
        mStreak = 0;
        mTmo    = 0;
        mErr    = 1'b0;
        mDcnt   = '0;
        mIcnt   = '0;
    endtask

    task automatic resetDut();
        nRST = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        modelReset();
    endtask

    // Expected outputs follow from who holds the grant and what the requester is asking for right now.
    task automatic checkModel();
        logic        dreq;
        logic        eRen;
        logic        eWen;
        logic        eIw;
        logic        eDw;
        logic [31:0] eAddr;
        logic [31:0] eStore;
        dreq   = dREN | dWEN;
        eRen   = 0;
        eWen   = 0;
        eIw    = 1;
        eDw    = 1;
        eAddr  = 0;
        eStore = 0;
        if (mGrant == 1) begin
            eWen   = dWEN;
            eRen   = dREN && !dWEN;
            eAddr  = daddr;
            eStore = dstore;
            eDw    = !(dreq && ram_rdy);
        end else if (mGrant == 2) begin
            eRen  = iREN;
            eAddr = iaddr;
            eIw   = !(iREN && ram_rdy);
        end
        checkOutput("rand ramREN", ramREN, eRen);
        checkOutput("rand ramWEN", ramWEN, eWen);
        checkOutput("rand ramaddr", ramaddr, eAddr);
        checkOutput("rand ramstore", ramstore, eStore);
        checkOutput("rand iwait", iwait, eIw);
        checkOutput("rand dwait", dwait, eDw);
        checkOutput("rand iload", iload, ramload);
        checkOutput("rand dload", dload, ramload);
        checkOutput("rand ram_err", ram_err, mErr);
`ifdef MEMCTRL_STATS_EN
        checkOutput("rand dword_cnt", dword_cnt, mDcnt);
        checkOutput("rand iword_cnt", iword_cnt, mIcnt);
`endif
    endtask

    task automatic modelStep();
        logic dreq;
        logic dServed;
        logic iServed;
        logic waiting;
        int   nxt;
        dreq    = dREN | dWEN;
        dServed = (mGrant == 1) && dreq && ram_rdy;
        iServed = (mGrant == 2) && iREN && ram_rdy;
        waiting = ((mGrant == 1) && dreq) || ((mGrant == 2) && iREN);
        nxt     = mGrant;
        if (mGrant == 0)
            nxt = dreq ? 1 : (iREN ? 2 : 0);
        else if (mGrant == 1) begin
            if (!dreq)
                nxt = iREN ? 2 : 0;
            else if (dServed && iREN && mStreak == MAX_D - 1)
                nxt = 2;
        end else if (iServed || !iREN)
            nxt = dreq ? 1 : (iREN ? 2 : 0);

        if (mGrant != 1 || nxt != 1)
            mStreak = 0;
        else if (dServed && mStreak < MAX_D - 1)
            mStreak++;

        if (mGrant != 0 && !ram_rdy && nxt == mGrant)
            mTmo = (waiting && mTmo < TMO_L) ? mTmo + 1 : mTmo;
        else
            mTmo = 0;
        if (mTmo == TMO_L)
            mErr = 1'b1;

        if (dServed) mDcnt++;
        if (iServed) mIcnt++;
        mGrant = nxt;
    endtask

    initial begin
        int dWords;
        int iWords;

        vecs[0]  = '{1,0,0,0, 32'h40, 0, 0, 0,             1,1,0,0, 0, 0};
        vecs[1]  = '{1,0,0,0, 32'h40, 0, 0, 0,             1,1,1,0, 32'h40, 0};
        vecs[2]  = '{1,0,0,0, 32'h40, 0, 0, 0,             1,1,1,0, 32'h40, 0};
        vecs[3]  = '{1,0,0,1, 32'h40, 0, 0, 32'hDEADBEEF,  0,1,1,0, 32'h40, 0};
        vecs[4]  = '{0,0,0,0, 32'h40, 0, 0, 0,             1,1,0,0, 32'h40, 0};
        vecs[5]  = '{0,0,1,1, 0, 32'h3100, 5, 0,           1,1,0,0, 0, 0};
        vecs[6]  = '{0,0,1,1, 0, 32'h3100, 5, 0,           1,0,0,1, 32'h3100, 5};
        vecs[7]  = '{0,0,1,1, 0, 32'h3100, 5, 0,           1,0,0,1, 32'h3100, 5};
        vecs[8]  = '{0,0,1,1, 0, 32'h3100, 5, 0,           1,0,0,1, 32'h3100, 5};
        vecs[9]  = '{0,0,0,0, 0, 32'h3100, 0, 0,           1,1,0,0, 32'h3100, 0};
        vecs[10] = '{1,1,0,1, 0, 32'h200, 0, 32'h11,       1,1,0,0, 0, 0};
        vecs[11] = '{1,1,0,1, 0, 32'h200, 0, 32'h22,       1,0,1,0, 32'h200, 0};
        vecs[12] = '{1,1,0,1, 0, 32'h204, 0, 32'h33,       1,0,1,0, 32'h204, 0};
        vecs[13] = '{1,0,0,0, 32'h80, 32'h204, 0, 0,       1,1,0,0, 32'h204, 0};
        vecs[14] = '{1,0,0,1, 32'h80, 0, 0, 32'h44,        0,1,1,0, 32'h80, 0};
        vecs[15] = '{0,0,0,0, 32'h80, 0, 0, 0,             1,1,0,0, 32'h80, 0};

        resetDut();
        #1;
        checkOutput("reset ramREN", ramREN, 0);
        checkOutput("reset ramWEN", ramWEN, 0);
        checkOutput("reset ramaddr", ramaddr, 0);
        checkOutput("reset iwait", iwait, 1);
        checkOutput("reset dwait", dwait, 1);
        checkOutput("reset ram_err", ram_err, 0);

        for (int v = 0; v < 16; v++) begin
            @(negedge CLK);
            applyStimulus(vecs[v].iren, vecs[v].dren, vecs[v].dwen, vecs[v].rdy,
                          vecs[v].ia, vecs[v].da, vecs[v].ds, vecs[v].rl);
            #1;
            checkOutput($sformatf("vec%0d iwait", v), iwait, vecs[v].eIwait);
            checkOutput($sformatf("vec%0d dwait", v), dwait, vecs[v].eDwait);
            checkOutput($sformatf("vec%0d ramREN", v), ramREN, vecs[v].eRen);
            checkOutput($sformatf("vec%0d ramWEN", v), ramWEN, vecs[v].eWen);
            checkOutput($sformatf("vec%0d ramaddr", v), ramaddr, vecs[v].eAddr);
            checkOutput($sformatf("vec%0d ramstore", v), ramstore, vecs[v].eStore);
            checkOutput($sformatf("vec%0d iload", v), iload, vecs[v].rl);
            checkOutput($sformatf("vec%0d dload", v), dload, vecs[v].rl);
            checkOutput($sformatf("vec%0d ram_err", v), ram_err, 0);
        end

        // Starvation guard: with both caches busy, every 9th service cycle belongs to the icache.
        resetDut();
        dWords = 0;
        iWords = 0;
        for (int k = 0; k <= 22; k++) begin
            @(negedge CLK);
            applyStimulus(1, 1, 0, 1, 32'h1000 + k, 32'h2000 + k, 0, k);
            #1;
            if (k == 0) begin
                checkOutput("streak idle dwait", dwait, 1);
                checkOutput("streak idle iwait", iwait, 1);
            end else begin
                checkOutput($sformatf("streak%0d dwait", k), dwait, ((k - 1) % 9) == 8);
                checkOutput($sformatf("streak%0d iwait", k), iwait, ((k - 1) % 9) != 8);
            end
            if (!dwait) dWords++;
            if (!iwait) iWords++;
        end
        checkOutput("streak dcache words", dWords, 20);
        checkOutput("streak icache words", iWords, 2);

        // Timeout: the 255th stalled cycle sets the sticky flag; only reset clears it.
        resetDut();
        for (int k = 0; k <= 300; k++) begin
            @(negedge CLK);
            applyStimulus(0, 1, 0, 0, 0, 32'h700, 0, 0);
            #1;
            if (k == 255) checkOutput("tmo before limit", ram_err, 0);
            if (k == 256) checkOutput("tmo at limit", ram_err, 1);
        end
        checkOutput("tmo still waiting ramREN", ramREN, 1);
        checkOutput("tmo still waiting dwait", dwait, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            applyStimulus(0, 1, 0, 1, 0, 32'h700, 0, 0);
        end
        #1;
        checkOutput("tmo sticky after rdy", ram_err, 1);
        resetDut();
        #1;
        checkOutput("tmo cleared by reset", ram_err, 0);

        // Asynchronous reset in the middle of a dcache block.
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            applyStimulus(0, 1, 0, 1, 0, 32'h500, 0, 32'h9);
        end
        #1;
        checkOutput("midrst before ramREN", ramREN, 1);
        checkOutput("midrst before dwait", dwait, 0);
        #1;
        nRST = 1'b0;
        #1;
        checkOutput("midrst ramREN", ramREN, 0);
        checkOutput("midrst ramWEN", ramWEN, 0);
        checkOutput("midrst dwait", dwait, 1);
`ifdef MEMCTRL_STATS_EN
        checkOutput("midrst dword_cnt", dword_cnt, 0);
        checkOutput("midrst iword_cnt", iword_cnt, 0);
`endif
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checkOutput("midrst idle ramREN", ramREN, 0);
        checkOutput("midrst idle dwait", dwait, 1);

        // Randomized traffic against the model.
        resetDut();
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
                          $urandom_range(0, 9) < 5, $urandom, $urandom, $urandom, $urandom);
            #1;
            checkModel();
            modelStep();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
